mul_product_reg: RTL
====================

Name: mul_product_reg

Overview:
- Datapath register stage of the 32-bit shift-add unsigned multiplier.
- Holds the multiplicand and the 64-bit product/multiplier register.
- Consumes SRL_ctrl, w_ctrl and ready from the multiplier control unit and the sum from the ADDU adder.
- Feeds LSB back to the control unit and product_hi/multiplicand to ADDU; presents the final product.

Parameters:
WIDTH, 32, operand width; product register is 2*WIDTH bits.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
load  input  1  capture new operands (honoured in IDLE and HOLD only)
multiplicand_in  input  WIDTH  multiplicand operand
multiplier_in  input  WIDTH  multiplier operand
SRL_ctrl  input  1  shift enable from control
w_ctrl  input  1  write ADDU result into upper half during this shift
ADDU_result  input  WIDTH+1  {carry, sum} of product_hi + multiplicand
ready  input  1  control signals end of multiplication
multiplicand  output  WIDTH  registered multiplicand, operand to ADDU
product_hi  output  WIDTH  product[2*WIDTH-1:WIDTH], operand to ADDU
LSB  output  1  product[0], to control
product  output  2*WIDTH  full product register
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse on entry to HOLD

Behaviour:
- Reset (rst=1 at edge, any state, including mid-multiplication):
  - state=IDLE; product, multiplicand, shift_cnt=0; busy=0, done=0.
  - rst has priority over all other inputs.
- States IDLE, SHIFT, HOLD; shift_cnt is 6 bits (0..WIDTH).
- IDLE:
  - load=1: multiplicand<=multiplicand_in; product<={WIDTH'b0, multiplier_in}; shift_cnt<=0; ->SHIFT; busy=1 from the next cycle.
  - All other inputs ignored.
- SHIFT:
  - SRL_ctrl=1 and shift_cnt<WIDTH:
    - w_ctrl=1: product<={ADDU_result, product[WIDTH-1:1]}. ADDU_result's carry becomes bit 2*WIDTH-1; no bits are lost.
    - w_ctrl=0: product<={1'b0, product[2*WIDTH-1:1]}.
    - shift_cnt<=shift_cnt+1.
  - SRL_ctrl=1 and shift_cnt==WIDTH: product unchanged (overshift protection); w_ctrl ignored.
  - SRL_ctrl=0: product and shift_cnt hold; w_ctrl ignored (no write without shift).
  - ready=1: ->HOLD; done=1 for exactly that next cycle; busy=0. If SRL_ctrl is also high on the same edge, the shift is applied first.
  - load ignored in SHIFT.
- HOLD:
  - product and multiplicand are stable; SRL_ctrl, w_ctrl and ready are ignored.
  - load=1 behaves exactly as load in IDLE (back-to-back multiplications).
- LSB, product_hi and product are combinational views of the product register, so no added latency.
- Alignment of w_ctrl with the LSB it was derived from belongs to the control unit. This block applies w_ctrl and SRL_ctrl as sampled at the same edge.
- Latency: load edge -> first shift possible on the next edge. WIDTH shifts followed by ready give a final product valid the cycle done=1.
- Arithmetic is unsigned only; ADDU_result width is fixed at WIDTH+1.

Test Plan:
- Reset: rst=1 during SHIFT after 10 shifts -> next cycle product=0, multiplicand=0, busy=0, done=0, state IDLE; SRL_ctrl=1 ignored until load.
- Basic: load 3 x 5, bench model drives w_ctrl=LSB with ADDU_result=product_hi+multiplicand, 32 SRL_ctrl pulses, then ready -> product=64'd15, done high one cycle, busy low.
- Carry path: load 0xFFFFFFFF x 0xFFFFFFFF, same model -> product=0xFFFFFFFE00000001; check carry bit lands in bit 63 on each write.
- Overshift/hold: after 32 shifts apply a 33rd SRL_ctrl with w_ctrl=1 -> product unchanged. In SHIFT with SRL_ctrl=0, w_ctrl=1 -> product unchanged.
- Load rules: load=1 with new operands during SHIFT -> ignored, result still correct. load in HOLD with 7 x 9 -> new run completes with product=63.
- Zero operand: 0 x 0xDEADBEEF and 0xDEADBEEF x 0 -> product=0, done pulses after ready.

Source files
------------

// File: rtl/mul_product_reg.sv
// ============================================================================
// Module   : mul_product_reg
// Brief    : Datapath register stage of a shift-add unsigned multiplier.
//            Holds the multiplicand and the combined product/multiplier register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_product_reg #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     multiplicand_in,
    input  logic [WIDTH-1:0]     multiplier_in,
    input  logic                 SRL_ctrl,
    input  logic                 w_ctrl,
    input  logic [WIDTH:0]       ADDU_result,
    input  logic                 ready,
    output logic [WIDTH-1:0]     multiplicand,
    output logic [WIDTH-1:0]     product_hi,
    output logic                 LSB,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_HOLD  = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(WIDTH);

    logic [1:0]           r_state;
    logic [CNT_W-1:0]     r_shift_cnt;
    logic [WIDTH-1:0]     r_multiplicand;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_shift_cnt    <= '0;
            r_multiplicand <= '0;
            r_product      <= '0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE, c_HOLD: begin
                    if (load) begin
                        r_multiplicand <= multiplicand_in;
                        r_product      <= {{WIDTH{1'b0}}, multiplier_in};
                        r_shift_cnt    <= '0;
                        r_state        <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    // The carry of the adder becomes the new MSB, so no bits are lost.
                    if (SRL_ctrl && (r_shift_cnt < c_CNT_MAX)) begin
                        if (w_ctrl) begin
                            r_product <= {ADDU_result, r_product[WIDTH-1:1]};
                        end else begin
                            r_product <= {1'b0, r_product[2*WIDTH-1:1]};
                        end
                        r_shift_cnt <= r_shift_cnt + CNT_W'(1);
                    end
                    if (ready) begin
                        r_state <= c_HOLD;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign multiplicand = r_multiplicand;
    assign product      = r_product;
    assign product_hi   = r_product[2*WIDTH-1:WIDTH];
    assign LSB          = r_product[0];
    assign busy         = (r_state == c_SHIFT);
    assign done         = r_done;

endmodule

`default_nettype wire
